// File: rtl/aes_inv_controller.sv
// Sequencer for the AES-128 inverse cipher: forward key schedule to K10,
// then AddRoundKey, nine inverse rounds and the final round, walking keys back.
module aes_inv_controller #(
    parameter int ROUND_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic       state_sel,
    output logic       state_en,
    output logic [1:0] stage_sel,
    output logic       key_sel,
    output logic       key_dir,
    output logic       key_en,
    output logic [7:0] rcon,
    output logic [3:0] round_idx,
    output logic       pt_en
);

    localparam logic [2:0] PH_LAST = 3'(ROUND_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        KEYFWD,
        INIT,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t     state;
    logic [2:0] ph;
    logic       active;
    logic       step;
    logic       capture;

    function automatic logic [7:0] rc(input logic [3:0] n);
        logic [7:0] v;
        v = 8'h00;
        unique case (n)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign active  = (state == KEYFWD) || (state == INIT) ||
                     (state == ROUND) || (state == FINAL);
    assign step    = !rst && active && (ph == PH_LAST);
    assign capture = !rst && load && ((state == IDLE) || (state == DONE));

    // Enables are the only outputs with a direct path from load, and only
    // while idle; everything else decodes registered state.
    assign state_en = capture ||
                      (step && ((state == INIT) || (state == ROUND) ||
                                (state == FINAL)));
    assign key_en   = capture ||
                      (step && ((state == KEYFWD) || (state == INIT) ||
                                (state == ROUND)));
    assign pt_en    = step && (state == FINAL);

    always_comb begin
        rcon = 8'h00;
        unique case (state)
            KEYFWD:  rcon = rc(round_idx + 4'd1);
            INIT:    rcon = rc(4'd10);
            ROUND:   rcon = rc(round_idx);
            default: rcon = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ph        <= 3'd0;
            round_idx <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            state_sel <= 1'b0;
            stage_sel <= 2'd0;
            key_sel   <= 1'b0;
            key_dir   <= 1'b0;
        end else begin
            if (active) begin
                ph <= step ? 3'd0 : ph + 3'd1;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (load) begin
                        state     <= KEYFWD;
                        ph        <= 3'd0;
                        round_idx <= 4'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state_sel <= 1'b0;
                        stage_sel <= 2'd0;
                        key_sel   <= 1'b1;
                        key_dir   <= 1'b0;
                    end
                end
                KEYFWD: begin
                    if (step) begin
                        if (round_idx >= 4'd9) begin
                            round_idx <= 4'd10;
                            state     <= INIT;
                            state_sel <= 1'b1;
                            stage_sel <= 2'd0;
                            key_dir   <= 1'b1;
                        end else begin
                            round_idx <= round_idx + 4'd1;
                        end
                    end
                end
                INIT: begin
                    if (step) begin
                        round_idx <= 4'd9;
                        state     <= ROUND;
                        stage_sel <= 2'd1;
                    end
                end
                ROUND: begin
                    if (step) begin
                        if (round_idx <= 4'd1) begin
                            round_idx <= 4'd0;
                            state     <= FINAL;
                            stage_sel <= 2'd2;
                        end else begin
                            round_idx <= round_idx - 4'd1;
                        end
                    end
                end
                FINAL: begin
                    if (step) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_sel <= 1'b0;
                        stage_sel <= 2'd0;
                        key_sel   <= 1'b0;
                        key_dir   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ph    <= 3'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_inv_controller.md
# aes_inv_controller

Sequencing controller for the AES-128 decryption (inverse cipher) path, the receive-side counterpart of the encryption round controller. On a `load` pulse it captures ciphertext and cipher key, then runs the key schedule forward to round key 10. It then walks the key schedule backwards while driving the inverse-round datapath through the initial AddRoundKey, nine full inverse rounds and the final round. Each step spans `ROUND_CYCLES` clocks to absorb the synchronous S-box (BRAM) read latency in the datapath.

## Interface
- `ROUND_CYCLES`, 2, clocks per key/round step (legal 1..8).

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `load` in 1: start request; accepted only in IDLE or DONE.
- `busy` out 1: high in KEYFWD, INIT, ROUND, FINAL.
- `done` out 1: high in DONE; held until the next accepted `load` or `rst`.
- `state_sel` out 1: 0 = state register takes ciphertext input; 1 = datapath feedback.
- `state_en` out 1: state register enable.
- `stage_sel` out 2: 0 = AddRoundKey only; 1 = InvShiftRows+InvSubBytes+AddRoundKey+InvMixColumns; 2 = same without InvMixColumns; 3 unused.
- `key_sel` out 1: 0 = key register takes cipher key input; 1 = expansion feedback.
- `key_dir` out 1: 0 = forward expansion step; 1 = inverse expansion step.
- `key_en` out 1: key register enable.
- `rcon` out 8: round constant for the current key step.
- `round_idx` out 4: index of the round key currently held in the key register.
- `pt_en` out 1: plaintext output register enable.

## Operation
- States: IDLE, KEYFWD, INIT, ROUND, FINAL, DONE.
- Phase counter `ph` (3 bits):
  - Clears on entry to every non-idle state.
  - Counts 0..ROUND_CYCLES-1 and wraps.
  - "Step edge" = the cycle with `ph == ROUND_CYCLES-1`.
- IDLE/DONE:
  - `load=1` gives `state_en=1`, `key_en=1`, `state_sel=0`, `key_sel=0`, all combinationally from `load`.
  - At that edge `round_idx` is set to 0 and the FSM moves to KEYFWD.
  - `done` clears on that edge.
- KEYFWD:
  - `key_sel=1`, `key_dir=0`, `rcon=RC(round_idx+1)`.
  - Each step edge: `key_en=1` and `round_idx` increments.
  - After the step edge with `round_idx==9`, `round_idx` becomes 10 and the FSM moves to INIT.
- INIT:
  - `stage_sel=0`, `state_sel=1`, `key_dir=1`, `rcon=RC(10)`.
  - Step edge: `state_en=1`, `key_en=1`, `round_idx` becomes 9, FSM moves to ROUND.
- ROUND:
  - `stage_sel=1`, `key_dir=1`, `rcon=RC(round_idx)`.
  - Each step edge: `state_en=1`, `key_en=1`, `round_idx` decrements.
  - Leaving `round_idx==1`, `round_idx` becomes 0 and the FSM moves to FINAL.
- FINAL:
  - `stage_sel=2`, `rcon=0`, `key_en=0`.
  - Step edge: `state_en=1`, `pt_en=1`, FSM moves to DONE.
- RC(1..10) = 01,02,04,08,10,20,40,80,1B,36. `rcon=0` in IDLE, DONE and FINAL.
- Outside step edges, all enables (`state_en`, `key_en`, `pt_en`) are 0. Select outputs hold their state values.
- `load` in KEYFWD/INIT/ROUND/FINAL is ignored with no side effect.
- `round_idx` never leaves the range 0..10.

## Timing
- Reset values:
  - FSM = IDLE, `ph=0`, `round_idx=0`.
  - All outputs 0: `busy`, `done`, `state_sel`, `state_en`, `stage_sel`, `key_sel`, `key_dir`, `key_en`, `rcon`, `pt_en`.
- `rst` mid-operation: FSM returns to IDLE on the next edge. No `pt_en` is issued, and `done` stays 0.
- `rst` and `load` in the same cycle: `rst` wins.
- Cycle timeline, with `load` sampled high in cycle 0:
  - `busy` high in cycles 1..21·ROUND_CYCLES.
  - Key step edges at cycles k·R for k=1..20. Cycles 1..10R are KEYFWD; cycles 10R+1..11R are INIT.
  - `pt_en` high in cycle 21·R only.
  - `done` high from cycle 21·R+1.
- For R=2: 10 forward key pulses at cycles 2,4,…,20. `pt_en` in cycle 42; `done` from cycle 43.
- `load` in DONE at cycle D:
  - `done` low from D+1.
  - The new run starts as if from IDLE.
  - Back-to-back throughput is 21·R+1 cycles per block.
- All outputs other than the IDLE/DONE load-capture enables are registered-state decodes. There are no combinational paths from `load` in active states.

## Test plan
- Reset: hold `rst` 3 cycles, then release with `load=0` -> every output 0, `round_idx=0`, stays in IDLE.
- FIPS-197 C.1 with a behavioural datapath, R=2: key 000102…0F, ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A -> plaintext 00112233445566778899AABBCCDDEEFF latched by `pt_en` in cycle 42, `done=1` at cycle 43.
- Key-step check, R=2: `rcon` sampled on every `key_en` pulse -> 01,02,04,08,10,20,40,80,1B,36 with `key_dir=0`, then 36,1B,80,40,20,10,08,04,02,01 with `key_dir=1`. `round_idx` sequence 0→10→0. `stage_sel` reads 0 once, then 1 nine times, then 2.
- `load` held high continuously through a run -> second run starts only from DONE: `done` high exactly 1 cycle (cycle 43), new ciphertext capture in that cycle, second `pt_en` at cycle 85.
- `rst` asserted at cycle 30 during ROUND -> IDLE at cycle 31, all outputs 0, no `pt_en`, `done` remains 0.
- R=1: `load` at cycle 0 -> enables pulse every cycle 1..21, `pt_en` in cycle 21, `done` from cycle 22, C.1 plaintext correct.
